// File: rtl/alu_pkg.sv
// Shared opcode, flag and FSM definitions for the execute-stage sequencer.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_LS  = 4'b0011;
  localparam logic [3:0] OP_SRS = 4'b0100;
  localparam logic [3:0] OP_URS = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_RRO = 4'b1000;
  localparam logic [3:0] OP_LRO = 4'b1001;
  localparam logic [3:0] OP_NOT = 4'b1111;

  localparam int FLAG_CR = 3;
  localparam int FLAG_OV = 2;
  localparam int FLAG_NG = 1;
  localparam int FLAG_ZR = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_LS) || (op == OP_SRS) || (op == OP_URS) ||
           (op == OP_RRO) || (op == OP_LRO);
  endfunction

  // 1010..1110 are holes in the opcode map
  function automatic logic is_legal(input logic [3:0] op);
    return (op <= OP_LRO) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Instruction handshake plus ALU operand/result bus between sequencer and its neighbours.
interface alu_exec_ctrl_if #(
  parameter int DW = 8
);
  import alu_pkg::*;

  logic          instr_valid;
  logic          instr_ready;
  logic [15:0]   instr;
  logic [DW-1:0] alu_ina;
  logic [DW-1:0] alu_inb;
  logic [3:0]    alu_op;
  logic [4:0]    alu_shamt;
  logic [DW-1:0] alu_out;
  logic          alu_cr;
  logic          alu_ov;
  logic          alu_ng;
  logic          alu_zr;

  modport master (
    output instr_valid, instr, alu_out, alu_cr, alu_ov, alu_ng, alu_zr,
    input  instr_ready, alu_ina, alu_inb, alu_op, alu_shamt
  );

  modport slave (
    input  instr_valid, instr, alu_out, alu_cr, alu_ov, alu_ng, alu_zr,
    output instr_ready, alu_ina, alu_inb, alu_op, alu_shamt
  );
endinterface

// File: rtl/regfile_8x8.sv
// General register file: one write port where writeback beats a host load to the
// same entry, a combinational host read port and two operand read ports.
module regfile_8x8
  import alu_pkg::*;
#(
  parameter  int NREGS = 8,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data
);

  logic [DW-1:0] mem [NREGS];

  // Per-entry mux: a load to a different entry still lands alongside writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wb_en && (wb_addr == AW'(i)))      mem[i] <= wb_data;
        else if (ld_en && (ld_addr == AW'(i))) mem[i] <= ld_data;
      end
    end
  end

  assign rd_data = mem[rd_addr];
  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: accepts an instruction, drives the ALU for one cycle,
// captures its result and writes it back to the register file.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter  int NREGS = 8,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic           clk,
  input  logic           rst,
  alu_exec_ctrl_if.slave bus,
  input  logic           ld_en,
  input  logic [AW-1:0]  ld_addr,
  input  logic [DW-1:0]  ld_data,
  input  logic [AW-1:0]  rd_addr,
  output logic [DW-1:0]  rd_data,
  output logic [3:0]     flags,
  output logic           wb_valid,
  output logic [AW-1:0]  wb_addr,
  output logic [DW-1:0]  wb_data,
  output logic           err,
  output logic           busy
);

  state_t        state, state_nx;
  logic [3:0]    op;
  logic [AW-1:0] rd_f, rs_f, rt_f;
  logic          accept, legal;
  logic [3:0]    op_p0;
  logic [AW-1:0] rd_p0;
  logic [DW-1:0] res_p1;
  logic [3:0]    flg_p1;
  logic [DW-1:0] ra_data, rb_data;

  assign op   = bus.instr[15:12];
  assign rd_f = bus.instr[11:9];
  assign rs_f = bus.instr[8:6];
  assign rt_f = bus.instr[5:3];

  assign bus.instr_ready = (state == S_IDLE) && !rst;
  assign accept          = bus.instr_valid && bus.instr_ready;
  assign legal           = is_legal(op);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept && legal) state_nx = S_EXEC;
      S_EXEC:  state_nx = S_WB;
      S_WB:    state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Stage p0: accept -- operands read before any same-edge register write
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_ina   <= '0;
      bus.alu_inb   <= '0;
      bus.alu_op    <= OP_AND;
      bus.alu_shamt <= '0;
      err           <= 1'b0;
    end else begin
      err <= accept && !legal;
      if (accept && legal) begin
        bus.alu_ina   <= ra_data;
        bus.alu_inb   <= rb_data;
        bus.alu_op    <= op;
        bus.alu_shamt <= is_shift(op) ? bus.instr[4:0] : 5'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && legal) begin
      op_p0 <= op;
      rd_p0 <= rd_f;
    end
  end

  // Stage p1: ALU result and flags held for writeback
  always_ff @(posedge clk) begin
    if (state == S_EXEC) begin
      res_p1 <= bus.alu_out;
      flg_p1 <= {bus.alu_cr, bus.alu_ov, bus.alu_ng, bus.alu_zr};
    end
  end

  // Stage p2: writeback; carry/overflow only meaningful for add and subtract
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= '0;
    end else if (state == S_WB) begin
      flags[FLAG_ZR] <= flg_p1[FLAG_ZR];
      flags[FLAG_NG] <= flg_p1[FLAG_NG];
      if (op_p0 == OP_ADD || op_p0 == OP_SUB) begin
        flags[FLAG_CR] <= flg_p1[FLAG_CR];
        flags[FLAG_OV] <= flg_p1[FLAG_OV];
      end
    end
  end

  assign wb_valid = (state == S_WB);
  assign wb_addr  = rd_p0;
  assign wb_data  = res_p1;
  assign busy     = (state != S_IDLE);

  regfile_8x8 #(.NREGS(NREGS), .DW(DW)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .wb_en   (wb_valid),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .ra_addr (rs_f),
    .ra_data (ra_data),
    .rb_addr (rt_f),
    .rb_data (rb_data)
  );

endmodule
